alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter BUS_DATA_WIDTH, default 64, operand/result width; legal values 32 and 64.
REQ-002 The block SHALL have parameter MUL_LATENCY, default 2, multiply latency in cycles; legal range 1..4.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 inValid  in  1  operation request.
REQ-007 outReady  out  1  unit can accept; high only in IDLE.
REQ-008 inAluControl  in  6  opcode: 011111 mul, 100000 mulh, 100001 mulhsu, 100010 mulhu, 100011 div, 100100 divu, 100101 rem, 100110 remu, 100111 mulw, 101000 divw, 101001 divuw, 101010 remw, 101011 remuw.
REQ-009 inData1, inData2  in  BUS_DATA_WIDTH  operands rs1, rs2 (already forwarded).
REQ-010 inDestRegister  in  5  destination tag, returned with result.
REQ-011 inFlush  in  1  kill in-flight operation.
REQ-012 outValid  out  1  result available.
REQ-013 inReady  in  1  consumer accepts result.
REQ-014 outResult  out  BUS_DATA_WIDTH  result.
REQ-015 outDestRegister  out  5  tag of the operation whose result is on outResult.

Function
REQ-016 Accept SHALL occur on a rising edge where inValid && outReady && !inFlush; operands, opcode and tag are captured at that edge.
REQ-017 States SHALL be IDLE, MUL, DIV, DONE; accept moves IDLE to MUL (mul* opcodes) or DIV (div/rem opcodes); one operation in flight.
REQ-018 An opcode outside REQ-008 SHALL be accepted and complete in 1 cycle with result 0.
REQ-019 MUL SHALL last MUL_LATENCY cycles; outValid SHALL rise MUL_LATENCY edges after the accept edge.
REQ-020 DIV SHALL be restoring, 1 quotient bit per cycle; outValid SHALL rise BUS_DATA_WIDTH+1 edges after accept for full-width ops and 33 for *w ops.
REQ-021 Divide by zero SHALL bypass iteration, with outValid 1 edge after accept: quotient all ones, remainder = dividend (*w ops: dividend low 32 bits, sign-extended).
REQ-022 Signed overflow (most-negative / -1) SHALL bypass iteration, with outValid 1 edge after accept: quotient = dividend, remainder 0.
REQ-023 Signed division SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-024 mul SHALL return the low BUS_DATA_WIDTH bits of the product; mulh, mulhsu and mulhu SHALL return the high BUS_DATA_WIDTH bits of the 2*BUS_DATA_WIDTH product (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-025 *w ops SHALL use operand bits [31:0] and return the 32-bit result sign-extended to 64 bits; they exist only when BUS_DATA_WIDTH=64, and otherwise follow REQ-018.
REQ-026 In DONE, outValid=1 and outResult/outDestRegister SHALL be held stable until an edge with inReady=1, after which the state is IDLE.
REQ-027 outValid and inReady both high with a new inValid SHALL NOT accept in the same edge; accept is possible from the following cycle (outReady high in IDLE).
REQ-028 inFlush=1 at any edge SHALL force IDLE at that edge, drop outValid and discard the result; flush and inValid together: flush wins, no accept.
REQ-029 outResult and outDestRegister SHALL be 0 whenever outValid=0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, outValid=0, outReady=1, outResult=0, outDestRegister=0, and clear the iteration counter and partial remainder.
REQ-031 rst_n low mid-operation SHALL abandon the operation; no result SHALL appear after rst_n rises.
REQ-032 Deassertion SHALL be sampled synchronously; the first accept is possible on the first edge with rst_n high.

Verification
REQ-033 mulhu, 64-bit, 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF, MUL_LATENCY=2 -> outValid at edge+2, outResult 0xFFFFFFFFFFFFFFFE.
REQ-034 div, -7 / 2 -> outValid at edge+65, outResult -3; rem, same operands -> outResult -1.
REQ-035 divu, x / 0 with x=0x1234 -> outValid at edge+1, outResult 0xFFFFFFFFFFFFFFFF; remu, same operands -> outResult 0x1234.
REQ-036 divw, 0x80000000 / 0xFFFFFFFF -> outValid at edge+1, outResult 0xFFFFFFFF80000000; remw, same operands -> outResult 0.
REQ-037 div started, inFlush at cycle 10 -> outValid never rises, outReady=1 next cycle, new mul accepted and correct.
REQ-038 Result held with inReady=0 for 5 cycles -> outResult/outDestRegister stable; rst_n pulsed mid-DIV -> outValid=0, outResult=0 immediately.

Source files
------------

// File: rtl/alu_muldiv.sv
// Multi-cycle integer multiply/divide unit (RV64M-style opcodes) with a valid/ready handshake.
// One operation in flight: fixed-latency multiply, restoring divide at one quotient bit per cycle.
module alu_muldiv #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned MUL_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inValid,
    output logic                      outReady,
    input  logic [5:0]                inAluControl,
    input  logic [BUS_DATA_WIDTH-1:0] inData1,
    input  logic [BUS_DATA_WIDTH-1:0] inData2,
    input  logic [4:0]                inDestRegister,
    input  logic                      inFlush,
    output logic                      outValid,
    input  logic                      inReady,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [4:0]                outDestRegister
);
    localparam int unsigned W    = BUS_DATA_WIDTH;
    localparam bit          HasW = (W == 64);

    localparam logic [5:0] OpMul    = 6'b011111;
    localparam logic [5:0] OpMulh   = 6'b100000;
    localparam logic [5:0] OpMulhsu = 6'b100001;
    localparam logic [5:0] OpMulhu  = 6'b100010;
    localparam logic [5:0] OpDiv    = 6'b100011;
    localparam logic [5:0] OpDivu   = 6'b100100;
    localparam logic [5:0] OpRem    = 6'b100101;
    localparam logic [5:0] OpRemu   = 6'b100110;
    localparam logic [5:0] OpMulw   = 6'b100111;
    localparam logic [5:0] OpDivw   = 6'b101000;
    localparam logic [5:0] OpDivuw  = 6'b101001;
    localparam logic [5:0] OpRemw   = 6'b101010;
    localparam logic [5:0] OpRemuw  = 6'b101011;

    localparam logic [W-1:0] MinNeg  = {1'b1, {(W-1){1'b0}}};
    localparam logic [6:0]   MulCnt  = 7'(MUL_LATENCY - 1);
    localparam logic [6:0]   DivLenF = 7'(W);
    localparam logic [6:0]   DivLenW = 7'd32;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    function automatic logic [W-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        return W'(s);
    endfunction

    state_e       state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [5:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0] rem_q, rem_d, quo_q, quo_d;
    logic         byp_q, byp_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic         rem_op_q, rem_op_d, w_op_q, w_op_d;
    logic [4:0]   tag_q, tag_d, dest_q, dest_d;
    logic         valid_q, valid_d;
    logic [W-1:0] result_q, result_d;

    // Request decode
    logic is_mul_in, is_div_in, is_w_in, is_sgn_in, is_rem_in;
    always_comb begin
        is_mul_in = 1'b0;
        is_div_in = 1'b0;
        is_w_in   = 1'b0;
        is_sgn_in = 1'b0;
        is_rem_in = 1'b0;
        case (inAluControl)
            OpMul, OpMulh, OpMulhsu, OpMulhu: is_mul_in = 1'b1;
            OpDiv:   begin is_div_in = 1'b1; is_sgn_in = 1'b1; end
            OpDivu:  is_div_in = 1'b1;
            OpRem:   begin is_div_in = 1'b1; is_sgn_in = 1'b1; is_rem_in = 1'b1; end
            OpRemu:  begin is_div_in = 1'b1; is_rem_in = 1'b1; end
            OpMulw:  begin is_mul_in = HasW; is_w_in = HasW; end
            OpDivw:  begin is_div_in = HasW; is_w_in = HasW; is_sgn_in = 1'b1; end
            OpDivuw: begin is_div_in = HasW; is_w_in = HasW; end
            OpRemw:  begin is_div_in = HasW; is_w_in = HasW; is_sgn_in = 1'b1; is_rem_in = 1'b1; end
            OpRemuw: begin is_div_in = HasW; is_w_in = HasW; is_rem_in = 1'b1; end
            default: ;
        endcase
    end

    // Divide setup: operand magnitudes, signs and the two bypass cases
    logic [W-1:0] a_ext, b_ext, a_mag, b_mag, dvd_s, byp_val, quo_load;
    logic         sa, sb, div_zero, ovf;
    always_comb begin
        a_ext    = is_w_in ? (is_sgn_in ? sext32(inData1[31:0]) : W'(inData1[31:0])) : inData1;
        b_ext    = is_w_in ? (is_sgn_in ? sext32(inData2[31:0]) : W'(inData2[31:0])) : inData2;
        sa       = is_sgn_in & a_ext[W-1];
        sb       = is_sgn_in & b_ext[W-1];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        dvd_s    = is_w_in ? sext32(inData1[31:0]) : inData1;
        div_zero = (b_ext == '0);
        ovf      = is_sgn_in && (&b_ext) &&
                   (is_w_in ? (inData1[31:0] == 32'h8000_0000) : (inData1 == MinNeg));
        if (is_rem_in) byp_val = div_zero ? dvd_s : '0;
        else           byp_val = div_zero ? '1 : dvd_s;
        // *w dividends sit in the upper half so 32 shifts consume exactly their bits
        quo_load = is_w_in ? (a_mag << 32) : a_mag;
    end

    // Multiplier on captured operands, 2W-bit two's-complement product
    logic [2*W-1:0] mul_a, mul_b, prod;
    logic [W-1:0]   mul_res;
    always_comb begin
        mul_a = {{W{(op_q == OpMulh || op_q == OpMulhsu) & a_q[W-1]}}, a_q};
        mul_b = {{W{(op_q == OpMulh) & b_q[W-1]}}, b_q};
        prod  = mul_a * mul_b;
        case (op_q)
            OpMul:                     mul_res = prod[W-1:0];
            OpMulh, OpMulhsu, OpMulhu: mul_res = prod[2*W-1:W];
            OpMulw:                    mul_res = sext32(prod[31:0]);
            default:                   mul_res = '0;
        endcase
    end

    // Restoring divide step and final sign fix-up
    logic [W:0]   shifted, trial;
    logic [W-1:0] q_fix, r_fix, div_res;
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, b_q};
        q_fix   = neg_q_q ? -quo_q : quo_q;
        r_fix   = neg_r_q ? -rem_q : rem_q;
        div_res = rem_op_q ? r_fix : q_fix;
        if (w_op_q) div_res = sext32(div_res[31:0]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        byp_d    = byp_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        rem_op_d = rem_op_q;
        w_op_d   = w_op_q;
        tag_d    = tag_q;
        dest_d   = dest_q;
        valid_d  = valid_q;
        result_d = result_q;
        if (inFlush) begin
            state_d  = StIdle;
            valid_d  = 1'b0;
            result_d = '0;
            dest_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inValid) begin
                        tag_d    = inDestRegister;
                        rem_op_d = is_rem_in;
                        w_op_d   = is_w_in;
                        if (is_div_in) begin
                            state_d = StDiv;
                            neg_q_d = sa ^ sb;
                            neg_r_d = sa;
                            b_d     = b_mag;
                            rem_d   = '0;
                            byp_d   = div_zero | ovf;
                            quo_d   = (div_zero | ovf) ? byp_val : quo_load;
                            cnt_d   = (div_zero | ovf) ? 7'd0 : (is_w_in ? DivLenW : DivLenF);
                        end else begin
                            // Unrecognised opcodes ride the multiply path with a zero result
                            state_d = StMul;
                            op_d    = is_mul_in ? inAluControl : 6'd0;
                            a_d     = inData1;
                            b_d     = inData2;
                            cnt_d   = is_mul_in ? MulCnt : 7'd0;
                        end
                    end
                end
                StMul: begin
                    if (cnt_q == 7'd0) begin
                        state_d  = StDone;
                        valid_d  = 1'b1;
                        result_d = mul_res;
                        dest_d   = tag_q;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                StDiv: begin
                    if (cnt_q == 7'd0) begin
                        state_d  = StDone;
                        valid_d  = 1'b1;
                        result_d = byp_q ? quo_q : div_res;
                        dest_d   = tag_q;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                        if (!trial[W]) begin
                            rem_d = trial[W-1:0];
                            quo_d = {quo_q[W-2:0], 1'b1};
                        end else begin
                            rem_d = shifted[W-1:0];
                            quo_d = {quo_q[W-2:0], 1'b0};
                        end
                    end
                end
                StDone: begin
                    if (inReady) begin
                        state_d  = StIdle;
                        valid_d  = 1'b0;
                        result_d = '0;
                        dest_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            byp_q    <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_op_q <= 1'b0;
            w_op_q   <= 1'b0;
            tag_q    <= '0;
            dest_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            byp_q    <= byp_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            rem_op_q <= rem_op_d;
            w_op_q   <= w_op_d;
            tag_q    <= tag_d;
            dest_q   <= dest_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign outReady        = (state_q == StIdle);
    assign outValid        = valid_q;
    assign outResult       = result_q;
    assign outDestRegister = dest_q;

endmodule
